act_skew_feeder: RTL and testbench

Activation feeder for the systolic array input edge. Buffers up to DEPTH activation vectors (one DW-bit element per array row) through a valid/ready port, then streams them into the array with the diagonal skew the array needs: row r lags row 0 by r cycles, with zero padding. It sits between the input buffer path and the array's `in_act` bus. It takes the place of the flat counter-driven memory walk used in bring-up, with parametrised height, element width and tile depth.

---
 rtl/act_skew_feeder.sv | 134 +++++++++++++
 tb/tb_act_skew_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Activation feeder: buffers a tile of row vectors, then streams it diagonally skewed
// (lane r lags lane 0 by r beats, zero padded) into the systolic array input edge.
module act_skew_feeder #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_vec,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  output logic               out_first,
  output logic               out_last,
  output logic [ROWS*DW-1:0] out_act
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(DEPTH + ROWS);

  typedef enum logic [0:0] {StLoad, StStream} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       n_q, n_d;
  logic [TW-1:0]       t_q, t_d;
  logic [ROWS*DW-1:0]  buf_q [DEPTH];
  logic [ROWS*DW-1:0]  act_q, act_d;
  logic                busy_q, busy_d;
  logic                valid_q;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                accept, start_eff, last_beat, beat_en;

  assign in_ready  = !rst && (state_q == StLoad) && (cnt_q < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign start_eff = (state_q == StLoad) && start && ((cnt_q != '0) || accept);
  assign last_beat = (int'(t_q) == int'(n_q) + int'(ROWS) - 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    t_d     = t_q;
    beat_en = 1'b0;
    busy_d  = 1'b0;
    first_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (accept) cnt_d = cnt_q + CW'(1);
        if (start_eff) begin
          state_d = StStream;
          n_d     = cnt_q + CW'(accept);
          t_d     = '0;
          beat_en = 1'b1;
          busy_d  = 1'b1;
          first_d = 1'b1;
        end
      end
      StStream: begin
        if (last_beat) begin
          state_d = StLoad;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          t_d     = t_q + TW'(1);
          beat_en = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
    last_d = beat_en && (int'(t_d) == int'(n_d) + int'(ROWS) - 2);

    // Next beat is built from the buffer with the same-cycle write forwarded, so the
    // registered output can show beat 0 right after the start edge.
    act_d = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (beat_en && (int'(t_d) - r == i) && (i < int'(n_d))) begin
          act_d[r*DW +: DW] = (accept && (cnt_q == CW'(i))) ? in_vec[r*DW +: DW]
                                                             : buf_q[i][r*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      n_q     <= '0;
      t_q     <= '0;
      act_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      t_q     <= t_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      valid_q <= busy_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Tile storage carries no reset; entries beyond the fill count are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (accept && (cnt_q == CW'(i))) buf_q[i] <= in_vec;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_act   = act_q;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed self-checking bench for act_skew_feeder (ROWS=4, DW=8, DEPTH=8).
module tb_act_skew_feeder;
  localparam int ROWS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int W     = ROWS * DW;

  logic         clk = 1'b0;
  logic         rst, in_valid, start;
  logic [W-1:0] in_vec;
  logic         in_ready, busy, done, out_valid, out_first, out_last;
  logic [W-1:0] out_act;

  always #5 clk = ~clk;

  act_skew_feeder #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_last (out_last),
    .out_act  (out_act)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] cap_act [64];
  logic [63:0]  cap_fm, cap_lm;
  int           cap_n;
  logic         cap_done, cap_busy, cap_rdy;
  logic [W-1:0] tile_m [DEPTH+1];

  // Reference skew: lane r of beat t is tile[t-r] lane r when that index is in the tile.
  function automatic logic [W-1:0] model_beat(input int t, input int n);
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      if ((t - r >= 0) && (t - r < n)) v[r*DW +: DW] = tile_m[t-r][r*DW +: DW];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Expects start already set; records beats until out_valid drops or the budget expires.
  task automatic capture(input int pulse_at, input bit keep_valid);
    tick();
    start = 1'b0;
    if (!keep_valid) in_valid = 1'b0;
    cap_n  = 0;
    cap_fm = '0;
    cap_lm = '0;
    for (int c = 0; c < 40; c++) begin
      if (!out_valid) break;
      cap_act[cap_n] = out_act;
      cap_fm[cap_n]  = out_first;
      cap_lm[cap_n]  = out_last;
      start = (cap_n == pulse_at);
      cap_n++;
      tick();
    end
    start    = 1'b0;
    cap_done = done;
    cap_busy = busy;
    cap_rdy  = in_ready;
  endtask

  task automatic test_reset();
    logic [W+5:0] outs;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'($urandom);
      start    = 1'($urandom);
      in_vec   = W'($urandom);
      tick();
      outs = {in_ready, busy, done, out_valid, out_first, out_last, out_act};
      n_cmp++;
      if (outs !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, outs);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: in_ready/busy got %b expected 10", {in_ready, busy});
    end
  endtask

  task automatic test_three_vector();
    logic [W-1:0] exp3 [6];
    exp3 = '{32'h00000001, 32'h00000211, 32'h00031221, 32'h04132200, 32'h14230000,
             32'h24000000};
    push(32'h04030201);
    push(32'h14131211);
    push(32'h24232221);
    start = 1'b1;
    capture(-1, 1'b0);
    n_cmp++;
    if (cap_n !== 6) begin
      n_err++;
      $display("FAIL three_count: got %0d beats expected 6", cap_n);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (cap_act[i] !== exp3[i]) begin
        n_err++;
        $display("FAIL three_beat%0d: got %h expected %h", i, cap_act[i], exp3[i]);
      end
    end
    n_cmp++;
    if (cap_fm !== 64'h1 || cap_lm !== 64'h20) begin
      n_err++;
      $display("FAIL three_flags: first %h last %h expected 1 20", cap_fm, cap_lm);
    end
    n_cmp++;
    if ({cap_done, cap_busy, cap_rdy} !== 3'b101) begin
      n_err++;
      $display("FAIL three_done: done/busy/in_ready got %b expected 101",
               {cap_done, cap_busy, cap_rdy});
    end
  endtask

  task automatic test_full_buffer();
    logic [W-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 8'((i + 1) * 16 + r);
      tile_m[i] = v;
      in_valid  = 1'b1;
      in_vec    = v;
      tick();
    end
    in_vec = 32'hDEADBEEF;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: got %b expected 0", in_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready_hold: got %b expected 0", in_ready);
    end
    start = 1'b1;
    capture(-1, 1'b1);
    n_cmp++;
    if (cap_n !== 11) begin
      n_err++;
      $display("FAIL full_count: got %0d beats expected 11", cap_n);
    end
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (cap_act[i] !== model_beat(i, 8)) begin
        n_err++;
        $display("FAIL full_beat%0d: got %h expected %h", i, cap_act[i], model_beat(i, 8));
      end
    end
    n_cmp++;
    if (cap_fm !== 64'h1 || cap_lm !== 64'h400 || cap_done !== 1'b1 || cap_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL full_flags: first %h last %h done %b in_ready %b expected 1 400 1 1",
               cap_fm, cap_lm, cap_done, cap_rdy);
    end
    tick();
    in_valid  = 1'b0;
    tile_m[0] = 32'hDEADBEEF;
    start     = 1'b1;
    capture(-1, 1'b0);
    n_cmp++;
    if (cap_n !== 4) begin
      n_err++;
      $display("FAIL held_count: got %0d beats expected 4", cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_act[i] !== model_beat(i, 1)) begin
        n_err++;
        $display("FAIL held_beat%0d: got %h expected %h", i, cap_act[i], model_beat(i, 1));
      end
    end
  endtask

  task automatic test_ignored_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL empty_start: busy/out_valid got %b expected 00", {busy, out_valid});
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL empty_start_late: busy got %b expected 0", busy);
    end
    push(32'h0A0B0C0D);
    push(32'h1A1B1C1D);
    start = 1'b1;
    capture(1, 1'b0);
    n_cmp++;
    if (cap_n !== 5 || cap_done !== 1'b1) begin
      n_err++;
      $display("FAIL mid_start: got %0d beats done %b expected 5 1", cap_n, cap_done);
    end
    tick();
    tick();
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_start_restream: busy/out_valid got %b expected 00",
               {busy, out_valid});
    end
  endtask

  task automatic test_same_cycle_start();
    logic [W-1:0] exp2 [5];
    exp2 = '{32'h00000001, 32'h00000211, 32'h00031200, 32'h04130000, 32'h14000000};
    push(32'h04030201);
    in_valid = 1'b1;
    in_vec   = 32'h14131211;
    start    = 1'b1;
    capture(-1, 1'b0);
    n_cmp++;
    if (cap_n !== 5) begin
      n_err++;
      $display("FAIL same_count: got %0d beats expected 5", cap_n);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cap_act[i] !== exp2[i]) begin
        n_err++;
        $display("FAIL same_beat%0d: got %h expected %h", i, cap_act[i], exp2[i]);
      end
    end
    n_cmp++;
    if (cap_lm !== 64'h10 || cap_done !== 1'b1) begin
      n_err++;
      $display("FAIL same_flags: last %h done %b expected 10 1", cap_lm, cap_done);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [W+5:0] outs;
    push(32'h04030201);
    push(32'h14131211);
    push(32'h24232221);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({out_valid, out_act} !== {1'b1, 32'h00031221}) begin
      n_err++;
      $display("FAIL rstmid_beat2: got %b %h expected 1 00031221", out_valid, out_act);
    end
    rst = 1'b1;
    tick();
    outs = {in_ready, busy, done, out_valid, out_first, out_last, out_act};
    n_cmp++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL rstmid_no_done cycle %0d: done/busy got %b expected 00", c,
                 {done, busy});
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL rstmid_start_ignored: busy/out_valid/in_ready got %b expected 001",
               {busy, out_valid, in_ready});
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_vec   = '0;
    test_reset();
    test_three_vector();
    test_full_buffer();
    test_ignored_start();
    test_same_cycle_start();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
